sdi_rx: RTL and testbench
=========================

SDI_RX -- requirements
Module: sdi_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning rx sample ticks per UART bit.
REQ-002 SHALL have parameter GAP_BITS, default 32, meaning the idle bit-times that end a burst and force frame realignment.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, receiver run; low holds both state machines idle.
REQ-006 SHALL have port baudDiv, input, 16, tick divisor; one sample tick every baudDiv+1 clocks.
REQ-007 SHALL have port sdiIn, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port sampleValid, output, 1, one-clock pulse marking a new sample.
REQ-009 SHALL have ports iSym and qSym, output, 16 each, the last assembled I and Q words.
REQ-010 SHALL have port sampleCount, output, 16, the sequence counter of the last frame.
REQ-011 SHALL have port seqError, output, 1, one-clock pulse when the frame counter is not the expected value.
REQ-012 SHALL have port framingError, output, 1, one-clock pulse on a bad stop bit.
REQ-013 SHALL have port errorCount, output, 8, saturating count of seqError plus framingError events.

Function
REQ-014 sdiIn SHALL pass a 2-flop synchronizer before any use.
REQ-015 Tick counter SHALL reload baudDiv and emit a tick at 0; it SHALL restart at every detected start edge so that bit centres align.
REQ-016 Byte receiver states SHALL be IDLE, START, DATA, STOP; format 8N1, LSB first.
REQ-017 IDLE->START SHALL occur on a synchronized 1->0 edge. At tick OVERSAMPLE/2 the line SHALL be low, else the receiver returns to IDLE (glitch reject, no error).
REQ-018 The 8 data bits SHALL be sampled every OVERSAMPLE ticks after the start-bit centre; the stop bit is sampled one further bit-time later.
REQ-019 A high stop bit SHALL give a one-clock byteValid (internal). A low stop bit SHALL pulse framingError, discard the byte, and wait for line high before IDLE.
REQ-020 Frame assembler states SHALL be CMSB, CLSB, IMSB, ILSB, QMSB, QLSB, in that order, advanced by byteValid, with big-endian byte order per word.
REQ-021 The clock after the QLSB byte, sampleValid SHALL pulse and iSym, qSym and sampleCount SHALL update together; they hold between pulses.
REQ-022 Expected count SHALL be 0 after a gap/reset, and received count + 1 (mod 2^16) after each frame. A mismatch SHALL pulse seqError coincident with sampleValid; the sample is still delivered.
REQ-023 A gap timer SHALL count ticks while the byte receiver is IDLE and clear on each start edge.
REQ-024 When the gap timer reaches GAP_BITS*OVERSAMPLE, the assembler SHALL return to CMSB and the expected count SHALL reset to 0; a partial frame is dropped silently.
REQ-025 framingError SHALL also return the assembler to CMSB; the expected count is kept.
REQ-026 errorCount SHALL saturate at 255. If both errors occur in the same clock, it increments by 1.
REQ-027 enable low SHALL force IDLE/CMSB, clear the gap timer and expected count, and suppress pulses; outputs hold.

Reset
REQ-028 Reset low SHALL asynchronously force IDLE and CMSB, synchronizer flops to 1, and counters, iSym, qSym, sampleCount, errorCount and expected count to 0.
REQ-029 Reset low SHALL also force all pulse outputs to 0; assertion mid-byte or mid-frame SHALL discard the partial data.

Structure
REQ-030 A shared package sdi_rx_pkg SHALL hold the rx and frame state enums, OVERSAMPLE and GAP_BITS defaults, and FRAME_BYTES=6.
REQ-031 The byte receiver (REQ-014..019) SHALL be sub-module uart_rx; sdi_rx holds the gap timer, assembler and error counter.

Verification
REQ-032 Test 1: baudDiv=3, send bytes 00 00 12 34 AB CD -> one sampleValid, iSym=16'h1234, qSym=16'hABCD, sampleCount=0, no seqError.
REQ-033 Test 2: three back-to-back frames with counts 0,1,3 -> three sampleValid; seqError only on the third; errorCount=1.
REQ-034 Test 3: byte 3 sent with stop bit low -> framingError pulse; the next 6 good bytes (count 0) give a sample with no seqError.
REQ-035 Test 4: send 3 bytes, idle 40 bit-times, then a full frame with count 0 -> exactly one sampleValid, correct data, no seqError.
REQ-036 Test 5: 1-tick low glitch on idle sdiIn -> no byteValid, no error; then assert reset mid-frame -> all outputs 0, next full frame decodes.
REQ-037 Test 6: force 300 framing errors -> errorCount=255 and holds.

Source files
------------

// File: rtl/sdi_rx_pkg.sv
// Shared types and defaults for the serial sample receiver.
package sdi_rx_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int GAP_BITS_DEF   = 32;
    localparam int FRAME_BYTES    = 6;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        FR_CMSB,
        FR_CLSB,
        FR_IMSB,
        FR_ILSB,
        FR_QMSB,
        FR_QLSB
    } frame_state_t;

    function automatic frame_state_t next_frame_state(input frame_state_t s);
        case (s)
            FR_CMSB: return FR_CLSB;
            FR_CLSB: return FR_IMSB;
            FR_IMSB: return FR_ILSB;
            FR_ILSB: return FR_QMSB;
            FR_QMSB: return FR_QLSB;
            default: return FR_CMSB;
        endcase
    endfunction

endpackage

// File: rtl/sdi_rx_uart.sv
// 8N1 oversampling byte receiver with synchronizer, tick generator and glitch reject.
module uart_rx
    import sdi_rx_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] baud_div,
    input  logic        sdi_in,
    output logic        tick,
    output logic        start_edge,
    output logic        rx_idle,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        framing_error
);

    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic            sync1, sync2, sync_d;
    logic [15:0]     tick_cnt;
    rx_state_t       state;
    logic [OS_W-1:0] os_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            break_wait;

    assign tick       = (tick_cnt == 16'd0);
    assign rx_idle    = (state == RX_IDLE);
    assign start_edge = enable && rx_idle && sync_d && !sync2;
    assign byte_data  = shift;

    // NOTE: every flop here uses <= so all registers see pre-edge values; blocking would chain the synchronizer into one stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            sync1  <= sdi_in;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    // Reloading on the start edge puts every later tick a whole number of periods after it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tick_cnt <= 16'd0;
        else if (start_edge || tick)
            tick_cnt <= baud_div;
        else
            tick_cnt <= tick_cnt - 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RX_IDLE;
            os_cnt        <= '0;
            bit_idx       <= 3'd0;
            shift         <= 8'd0;
            break_wait    <= 1'b0;
            byte_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            byte_valid    <= 1'b0;
            framing_error <= 1'b0;
            if (!enable) begin
                state      <= RX_IDLE;
                os_cnt     <= '0;
                bit_idx    <= 3'd0;
                break_wait <= 1'b0;
            end else begin
                case (state)
                    RX_IDLE: begin
                        if (start_edge) begin
                            state  <= RX_START;
                            os_cnt <= '0;
                        end
                    end
                    RX_START: begin
                        if (tick) begin
                            if (os_cnt == OS_HALF) begin
                                os_cnt  <= '0;
                                bit_idx <= 3'd0;
                                state   <= sync2 ? RX_IDLE : RX_DATA;
                            end else begin
                                os_cnt <= os_cnt + 1'b1;
                            end
                        end
                    end
                    RX_DATA: begin
                        if (tick) begin
                            if (os_cnt == OS_LAST) begin
                                os_cnt  <= '0;
                                shift   <= {sync2, shift[7:1]};
                                bit_idx <= bit_idx + 3'd1;
                                if (bit_idx == 3'd7)
                                    state <= RX_STOP;
                            end else begin
                                os_cnt <= os_cnt + 1'b1;
                            end
                        end
                    end
                    RX_STOP: begin
                        if (break_wait) begin
                            // A low stop bit means a break; rearm only once the line is idle again.
                            if (sync2) begin
                                break_wait <= 1'b0;
                                state      <= RX_IDLE;
                            end
                        end else if (tick) begin
                            if (os_cnt == OS_LAST) begin
                                os_cnt <= '0;
                                if (sync2) begin
                                    byte_valid <= 1'b1;
                                    state      <= RX_IDLE;
                                end else begin
                                    framing_error <= 1'b1;
                                    break_wait    <= 1'b1;
                                end
                            end else begin
                                os_cnt <= os_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/sdi_rx.sv
// Serial I/Q sample receiver: byte receiver, gap timer, six-byte frame assembler and error counter.
module sdi_rx
    import sdi_rx_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int GAP_BITS   = GAP_BITS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] baudDiv,
    input  logic        sdiIn,
    output logic        sampleValid,
    output logic [15:0] iSym,
    output logic [15:0] qSym,
    output logic [15:0] sampleCount,
    output logic        seqError,
    output logic        framingError,
    output logic [7:0]  errorCount
);

    localparam int GAP_TICKS = GAP_BITS * OVERSAMPLE;
    localparam int GAP_W     = $clog2(GAP_TICKS + 1);
    localparam int BUF_W     = (FRAME_BYTES - 1) * 8;

    logic             tick, start_edge, rx_idle, byte_valid, rx_framing_error;
    logic [7:0]       byte_data;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_hit;
    frame_state_t     frame_state;
    logic [BUF_W-1:0] frame_buf;
    logic [15:0]      expected;
    logic [15:0]      rx_count;
    logic             sample_done, seq_mismatch;

    uart_rx #(.OVERSAMPLE(OVERSAMPLE)) u_uart_rx (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .baud_div      (baudDiv),
        .sdi_in        (sdiIn),
        .tick          (tick),
        .start_edge    (start_edge),
        .rx_idle       (rx_idle),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .framing_error (rx_framing_error)
    );

    assign framingError = rx_framing_error;
    assign gap_hit      = (gap_cnt == GAP_W'(GAP_TICKS));
    assign rx_count     = frame_buf[BUF_W-1 -: 16];
    assign sample_done  = enable && !gap_hit && !rx_framing_error
                          && byte_valid && (frame_state == FR_QLSB);
    assign seq_mismatch = sample_done && (rx_count != expected);

    // The timer saturates so a long idle line keeps the assembler parked at CMSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            gap_cnt <= '0;
        else if (!enable || start_edge)
            gap_cnt <= '0;
        else if (tick && rx_idle && !gap_hit)
            gap_cnt <= gap_cnt + 1'b1;
    end

    // NOTE: the byte buffer is an ordinary register, so it takes the async reset like everything else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_state <= FR_CMSB;
            frame_buf   <= '0;
            expected    <= 16'd0;
            sampleValid <= 1'b0;
            seqError    <= 1'b0;
            iSym        <= 16'd0;
            qSym        <= 16'd0;
            sampleCount <= 16'd0;
        end else begin
            sampleValid <= 1'b0;
            seqError    <= 1'b0;
            if (!enable || gap_hit) begin
                frame_state <= FR_CMSB;
                expected    <= 16'd0;
            end else if (rx_framing_error) begin
                frame_state <= FR_CMSB;
            end else if (byte_valid) begin
                frame_state <= next_frame_state(frame_state);
                if (sample_done) begin
                    sampleValid <= 1'b1;
                    seqError    <= seq_mismatch;
                    sampleCount <= rx_count;
                    iSym        <= frame_buf[23:8];
                    qSym        <= {frame_buf[7:0], byte_data};
                    expected    <= rx_count + 16'd1;
                end else begin
                    frame_buf <= {frame_buf[BUF_W-9:0], byte_data};
                end
            end
        end
    end

    // Simultaneous sequence and framing errors count as one event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            errorCount <= 8'd0;
        else if ((seq_mismatch || rx_framing_error) && errorCount != 8'hFF)
            errorCount <= errorCount + 8'd1;
    end

endmodule

// File: tb/tb_sdi_rx.sv
// Directed bench for sdi_rx: frames, sequence/framing errors, gap realignment, reset and saturation.
module tb_sdi_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] baudDiv;
    logic        sdiIn;
    logic        sampleValid;
    logic [15:0] iSym, qSym, sampleCount;
    logic        seqError, framingError;
    logic [7:0]  errorCount;

    int tests_run = 0;
    int tests_failed = 0;
    int sv_cnt = 0, se_cnt = 0, se_sv_cnt = 0, fe_cnt = 0, bv_cnt = 0;
    int sv0, se0, se_sv0, fe0, bv0;

    sdi_rx dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .baudDiv      (baudDiv),
        .sdiIn        (sdiIn),
        .sampleValid  (sampleValid),
        .iSym         (iSym),
        .qSym         (qSym),
        .sampleCount  (sampleCount),
        .seqError     (seqError),
        .framingError (framingError),
        .errorCount   (errorCount)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sampleValid) sv_cnt++;
        if (seqError) se_cnt++;
        if (seqError && sampleValid) se_sv_cnt++;
        if (framingError) fe_cnt++;
        if (dut.u_uart_rx.byte_valid) bv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        sv0 = sv_cnt; se0 = se_cnt; se_sv0 = se_sv_cnt; fe0 = fe_cnt; bv0 = bv_cnt;
    endtask

    task automatic drive_bit(input logic v);
        sdiIn = v;
        repeat ((int'(baudDiv) + 1) * 16) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        repeat (n) drive_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        if (!stop_ok) drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [15:0] c, input logic [15:0] i_w, input logic [15:0] q_w);
        send_byte(c[15:8], 1'b1);
        send_byte(c[7:0], 1'b1);
        send_byte(i_w[15:8], 1'b1);
        send_byte(i_w[7:0], 1'b1);
        send_byte(q_w[15:8], 1'b1);
        send_byte(q_w[7:0], 1'b1);
        idle_bits(1);
    endtask

    initial begin
        reset   = 1'b0;
        enable  = 1'b1;
        baudDiv = 16'd3;
        sdiIn   = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_isym", iSym, 0);
        check("reset_qsym", qSym, 0);
        check("reset_count", sampleCount, 0);
        check("reset_errcnt", errorCount, 0);
        check("reset_pulses", {sampleValid, seqError, framingError}, 0);
        reset = 1'b1;
        idle_bits(2);

        // Test 1: single frame at baudDiv=3
        snap();
        send_frame(16'h0000, 16'h1234, 16'hABCD);
        check("t1_nsamples", sv_cnt - sv0, 1);
        check("t1_isym", iSym, 16'h1234);
        check("t1_qsym", qSym, 16'hABCD);
        check("t1_count", sampleCount, 16'h0000);
        check("t1_seqerr", se_cnt - se0, 0);

        baudDiv = 16'd1;
        idle_bits(40);

        // Test 2: counts 0,1,3 back to back
        snap();
        send_frame(16'h0000, 16'h1111, 16'h2222);
        send_frame(16'h0001, 16'h3333, 16'h4444);
        check("t2_two_samples", sv_cnt - sv0, 2);
        check("t2_no_seqerr_yet", se_cnt - se0, 0);
        send_frame(16'h0003, 16'h5555, 16'h6666);
        check("t2_nsamples", sv_cnt - sv0, 3);
        check("t2_seqerr", se_cnt - se0, 1);
        check("t2_seqerr_with_sample", se_sv_cnt - se_sv0, 1);
        check("t2_count", sampleCount, 16'h0003);
        check("t2_isym", iSym, 16'h5555);
        check("t2_errcnt", errorCount, 1);

        idle_bits(40);

        // Test 3: bad stop bit on byte 3, then a clean frame
        snap();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h12, 1'b0);
        check("t3_framing", fe_cnt - fe0, 1);
        check("t3_no_sample_yet", sv_cnt - sv0, 0);
        send_frame(16'h0000, 16'hCAFE, 16'hBEEF);
        check("t3_nsamples", sv_cnt - sv0, 1);
        check("t3_isym", iSym, 16'hCAFE);
        check("t3_qsym", qSym, 16'hBEEF);
        check("t3_seqerr", se_cnt - se0, 0);
        check("t3_errcnt", errorCount, 2);

        idle_bits(40);

        // Test 4: partial frame dropped by the idle gap
        snap();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h77, 1'b1);
        idle_bits(40);
        send_frame(16'h0000, 16'h2468, 16'h1357);
        check("t4_nsamples", sv_cnt - sv0, 1);
        check("t4_isym", iSym, 16'h2468);
        check("t4_qsym", qSym, 16'h1357);
        check("t4_count", sampleCount, 16'h0000);
        check("t4_seqerr", se_cnt - se0, 0);

        idle_bits(40);

        // Test 5: one-tick glitch, then reset mid-frame
        snap();
        sdiIn = 1'b0;
        repeat (int'(baudDiv) + 1) @(negedge clk);
        sdiIn = 1'b1;
        idle_bits(20);
        check("t5_glitch_bytes", bv_cnt - bv0, 0);
        check("t5_glitch_framing", fe_cnt - fe0, 0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h99, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        reset = 1'b0;
        #1;
        check("t5_rst_isym", iSym, 0);
        check("t5_rst_qsym", qSym, 0);
        check("t5_rst_count", sampleCount, 0);
        check("t5_rst_errcnt", errorCount, 0);
        check("t5_rst_pulses", {sampleValid, seqError, framingError}, 0);
        sdiIn = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        idle_bits(4);
        snap();
        send_frame(16'h0000, 16'h5A5A, 16'h0F0F);
        check("t5_nsamples", sv_cnt - sv0, 1);
        check("t5_isym", iSym, 16'h5A5A);
        check("t5_qsym", qSym, 16'h0F0F);
        check("t5_seqerr", se_cnt - se0, 0);

        // Test 6: error counter saturation, then enable low suppresses errors
        baudDiv = 16'd0;
        idle_bits(4);
        snap();
        repeat (300) send_byte(8'h00, 1'b0);
        check("t6_framing_pulses", fe_cnt - fe0, 300);
        check("t6_errcnt_sat", errorCount, 255);
        repeat (5) send_byte(8'h00, 1'b0);
        check("t6_errcnt_hold", errorCount, 255);
        snap();
        enable = 1'b0;
        send_byte(8'h00, 1'b0);
        check("t6_disabled_framing", fe_cnt - fe0, 0);
        check("t6_disabled_errcnt", errorCount, 255);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
